// File: rtl/snn_motion_filter.sv
// LIF spiking filter over the motion grid: one neuron per cycle, outputs 18 cycles after frame_done.
// No backpressure; frame_done while busy is dropped and flagged on overrun.
module snn_motion_filter #(
  parameter int GRID_SIZE      = 4,
  parameter int V_WIDTH        = 8,
  parameter int W_IN           = 48,
  parameter int W_LAT          = 8,
  parameter int LEAK_SHIFT     = 2,
  parameter int V_TH           = 64,
  parameter int CONFIRM_FRAMES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   frame_done,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]         grid_activity,
  input  logic                                   motion_detected,
  input  logic [7:0]                             motion_intensity,
  output logic [GRID_SIZE*GRID_SIZE-1:0]         spike_map,
  output logic [$clog2(GRID_SIZE*GRID_SIZE):0]   active_cells,
  output logic                                   alarm,
  output logic [7:0]                             alarm_intensity,
  output logic                                   update_valid,
  output logic                                   overrun
);

  localparam int GRID_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int KW         = (GRID_CELLS > 1) ? $clog2(GRID_CELLS) : 1;
  localparam int CW         = $clog2(GRID_CELLS) + 1;
  localparam int SW         = V_WIDTH + 3;
  localparam int SKW        = $clog2(CONFIRM_FRAMES + 1);
  localparam int V_MAX      = (1 << V_WIDTH) - 1;

  function automatic logic [GRID_CELLS-1:0] col_mask(input int c);
    logic [GRID_CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < GRID_CELLS; i++) begin
      if ((i % GRID_SIZE) == c) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [GRID_CELLS-1:0] x);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < GRID_CELLS; i++) n = n + CW'(x[i]);
    return n;
  endfunction

  localparam logic [GRID_CELLS-1:0] COL_FIRST = col_mask(0);
  localparam logic [GRID_CELLS-1:0] COL_LAST  = col_mask(GRID_SIZE - 1);
  localparam logic [KW-1:0]         K_LAST    = KW'(GRID_CELLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DECIDE} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [GRID_CELLS-1:0]   act_q, act_d;
  logic                    mdet_q, mdet_d;
  logic [7:0]              mint_q, mint_d;
  logic [GRID_CELLS-1:0]   spk_acc_q, spk_acc_d;
  logic [SKW-1:0]          streak_q, streak_d;
  logic [GRID_CELLS-1:0]   spike_map_q, spike_map_d;
  logic [CW-1:0]           active_cells_q, active_cells_d;
  logic                    alarm_q, alarm_d;
  logic [7:0]              alarm_int_q, alarm_int_d;
  logic                    update_valid_q, update_valid_d;
  logic                    overrun_q, overrun_d;
  logic [V_WIDTH-1:0]      v_q [GRID_CELLS];

  // Neighbour activity realigned so bit i holds the N/S/W/E neighbour of cell i (no wrap).
  logic [GRID_CELLS-1:0] nb_n, nb_s, nb_w, nb_e;
  assign nb_n = act_q << GRID_SIZE;
  assign nb_s = act_q >> GRID_SIZE;
  assign nb_w = (act_q << 1) & ~COL_FIRST;
  assign nb_e = (act_q >> 1) & ~COL_LAST;

  logic [V_WIDTH-1:0] v_cur, v_clamp;
  logic [2:0]         nb;
  logic [SW-1:0]      sum;
  logic               fire;
  logic               v_we;
  logic [CW-1:0]      pop;

  always_comb begin
    v_cur = v_q[k_q];
    nb    = 3'(nb_n[k_q]) + 3'(nb_s[k_q]) + 3'(nb_w[k_q]) + 3'(nb_e[k_q]);
    sum   = SW'(v_cur) - SW'(v_cur >> LEAK_SHIFT)
          + (act_q[k_q] ? SW'(W_IN) : SW'(0))
          + SW'(W_LAT) * SW'(nb);
    if (sum > SW'(V_MAX)) v_clamp = {V_WIDTH{1'b1}};
    else                  v_clamp = sum[V_WIDTH-1:0];
    fire  = (v_clamp >= V_WIDTH'(V_TH));
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    act_d          = act_q;
    mdet_d         = mdet_q;
    mint_d         = mint_q;
    spk_acc_d      = spk_acc_q;
    streak_d       = streak_q;
    spike_map_d    = spike_map_q;
    active_cells_d = active_cells_q;
    alarm_d        = alarm_q;
    alarm_int_d    = alarm_int_q;
    update_valid_d = 1'b0;
    overrun_d      = 1'b0;
    v_we           = 1'b0;
    pop            = popcnt(spk_acc_q);

    case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          act_d     = grid_activity;
          mdet_d    = motion_detected;
          mint_d    = motion_intensity;
          k_d       = '0;
          spk_acc_d = '0;
          state_d   = S_UPDATE;
        end
      end
      S_UPDATE: begin
        overrun_d      = frame_done;
        v_we           = 1'b1;
        spk_acc_d[k_q] = fire;
        if (k_q == K_LAST) state_d = S_DECIDE;
        else               k_d     = k_q + 1'b1;
      end
      S_DECIDE: begin
        overrun_d      = frame_done;
        spike_map_d    = spk_acc_q;
        active_cells_d = pop;
        if ((pop != '0) && mdet_q) begin
          if (streak_q != SKW'(CONFIRM_FRAMES)) streak_d = streak_q + 1'b1;
        end else begin
          streak_d = '0;
        end
        alarm_d        = (streak_d == SKW'(CONFIRM_FRAMES));
        alarm_int_d    = alarm_d ? mint_q : 8'h00;
        update_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      act_q          <= '0;
      mdet_q         <= 1'b0;
      mint_q         <= 8'h00;
      spk_acc_q      <= '0;
      streak_q       <= '0;
      spike_map_q    <= '0;
      active_cells_q <= '0;
      alarm_q        <= 1'b0;
      alarm_int_q    <= 8'h00;
      update_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      for (int i = 0; i < GRID_CELLS; i++) v_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      act_q          <= act_d;
      mdet_q         <= mdet_d;
      mint_q         <= mint_d;
      spk_acc_q      <= spk_acc_d;
      streak_q       <= streak_d;
      spike_map_q    <= spike_map_d;
      active_cells_q <= active_cells_d;
      alarm_q        <= alarm_d;
      alarm_int_q    <= alarm_int_d;
      update_valid_q <= update_valid_d;
      overrun_q      <= overrun_d;
      if (v_we) v_q[k_q] <= fire ? '0 : v_clamp;
    end
  end

  assign spike_map       = spike_map_q;
  assign active_cells    = active_cells_q;
  assign alarm           = alarm_q;
  assign alarm_intensity = alarm_int_q;
  assign update_valid    = update_valid_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_snn_motion_filter.sv
// Directed bench for snn_motion_filter with default parameters (4x4 grid).
module tb_snn_motion_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_done = 1'b0;
  logic [15:0] grid_activity = '0;
  logic        motion_detected = 1'b0;
  logic [7:0]  motion_intensity = '0;
  logic [15:0] spike_map;
  logic [4:0]  active_cells;
  logic        alarm;
  logic [7:0]  alarm_intensity;
  logic        update_valid;
  logic        overrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic got;

  snn_motion_filter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_done       (frame_done),
    .grid_activity    (grid_activity),
    .motion_detected  (motion_detected),
    .motion_intensity (motion_intensity),
    .spike_map        (spike_map),
    .active_cells     (active_cells),
    .alarm            (alarm),
    .alarm_intensity  (alarm_intensity),
    .update_valid     (update_valid),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    frame_done = 1'b0;
    grid_activity = '0;
    motion_detected = 1'b0;
    motion_intensity = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pulses frame_done for one cycle, then waits (bounded) for update_valid.
  task automatic run_frame(input logic [15:0] act, input logic md, input logic [7:0] mi,
                           output logic ok);
    grid_activity = act;
    motion_detected = md;
    motion_intensity = mi;
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    grid_activity = '0;
    motion_detected = 1'b0;
    motion_intensity = 8'h33;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (update_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({spike_map, active_cells} !== 21'h0) begin
      n_fail++; $display("FAIL reset_map: got %h/%0d expected 0/0", spike_map, active_cells);
    end
    n_checks++;
    if ({alarm, alarm_intensity, update_valid, overrun} !== 11'h0) begin
      n_fail++; $display("FAIL reset_flags: got a=%b ai=%h uv=%b ov=%b expected all 0",
                         alarm, alarm_intensity, update_valid, overrun);
    end
  endtask

  task automatic test_isolated();
    do_reset();
    run_frame(16'h0020, 1'b0, 8'h00, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0000) begin
      n_fail++; $display("FAIL iso_f1: got uv=%b map=%h expected 1/0000", got, spike_map);
    end
    run_frame(16'h0020, 1'b0, 8'h00, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0020 || active_cells !== 5'd1) begin
      n_fail++; $display("FAIL iso_f2: got uv=%b map=%h n=%0d expected 1/0020/1", got, spike_map, active_cells);
    end
    run_frame(16'h0020, 1'b0, 8'h00, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0000) begin
      n_fail++; $display("FAIL iso_f3_vreset: got uv=%b map=%h expected 1/0000", got, spike_map);
    end
  endtask

  task automatic test_neighbours();
    do_reset();
    run_frame(16'h0272, 1'b0, 8'h00, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0020 || active_cells !== 5'd1) begin
      n_fail++; $display("FAIL nbr_f1: got uv=%b map=%h n=%0d expected 1/0020/1", got, spike_map, active_cells);
    end
    // Neighbours sit at 56; second frame takes them to 98 while inactive cells stay below threshold.
    run_frame(16'h0272, 1'b0, 8'h00, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0272 || active_cells !== 5'd5) begin
      n_fail++; $display("FAIL nbr_f2: got uv=%b map=%h n=%0d expected 1/0272/5", got, spike_map, active_cells);
    end
  endtask

  task automatic test_leak_edges();
    do_reset();
    run_frame(16'h0009, 1'b0, 8'h00, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0000) begin
      n_fail++; $display("FAIL leak_load: got uv=%b map=%h expected 1/0000", got, spike_map);
    end
    for (int f = 0; f < 3; f++) begin
      run_frame(16'h0000, 1'b0, 8'h00, got);
      n_checks++;
      if (got !== 1'b1 || spike_map !== 16'h0000 || active_cells !== 5'd0) begin
        n_fail++; $display("FAIL leak_zero%0d: got uv=%b map=%h n=%0d expected 1/0000/0",
                           f, got, spike_map, active_cells);
      end
    end
    // v[0]=21 -> 21-5+48 = 64 hits threshold exactly.
    run_frame(16'h0001, 1'b0, 8'h00, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0001) begin
      n_fail++; $display("FAIL leak_thresh: got uv=%b map=%h expected 1/0001", got, spike_map);
    end
    // Cells 3 and 4 are index-adjacent but not grid neighbours; v[3]=16 -> 60, no spike.
    run_frame(16'h0018, 1'b0, 8'h00, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0000) begin
      n_fail++; $display("FAIL edge_nowrap: got uv=%b map=%h expected 1/0000", got, spike_map);
    end
  endtask

  task automatic test_alarm();
    do_reset();
    run_frame(16'hFFFF, 1'b1, 8'h5A, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'hFFFF || active_cells !== 5'd16 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL alarm_f1: got uv=%b map=%h n=%0d a=%b expected 1/ffff/16/0",
                         got, spike_map, active_cells, alarm);
    end
    run_frame(16'hFFFF, 1'b1, 8'h5A, got);
    n_checks++;
    if (got !== 1'b1 || alarm !== 1'b1 || alarm_intensity !== 8'h5A) begin
      n_fail++; $display("FAIL alarm_f2: got uv=%b a=%b ai=%h expected 1/1/5a", got, alarm, alarm_intensity);
    end
    run_frame(16'hFFFF, 1'b0, 8'h5A, got);
    n_checks++;
    if (got !== 1'b1 || active_cells !== 5'd16 || alarm !== 1'b0 || alarm_intensity !== 8'h00) begin
      n_fail++; $display("FAIL alarm_f3: got uv=%b n=%0d a=%b ai=%h expected 1/16/0/00",
                         got, active_cells, alarm, alarm_intensity);
    end
  endtask

  task automatic test_latency_overrun();
    int uv_cnt, uv_at, ov_cnt, ov_at;
    do_reset();
    uv_cnt = 0; uv_at = -1; ov_cnt = 0; ov_at = -1;
    grid_activity = 16'hFFFF; motion_detected = 1'b1; motion_intensity = 8'h11;
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 22; c++) begin
      frame_done = (c == 5);
      grid_activity = (c == 5) ? 16'h0000 : 16'hFFFF;
      motion_detected = (c != 5);
      motion_intensity = 8'hEE;
      if (update_valid) begin uv_cnt++; uv_at = c; end
      if (overrun) begin ov_cnt++; ov_at = c; end
      @(posedge clk);
      #1;
    end
    frame_done = 1'b0;
    n_checks++;
    if (uv_cnt !== 1 || uv_at !== 18) begin
      n_fail++; $display("FAIL latency: got %0d pulses at T+%0d expected 1 at T+18", uv_cnt, uv_at);
    end
    n_checks++;
    if (ov_cnt !== 1 || ov_at !== 6) begin
      n_fail++; $display("FAIL overrun: got %0d pulses at T+%0d expected 1 at T+6", ov_cnt, ov_at);
    end
    n_checks++;
    if (spike_map !== 16'hFFFF || active_cells !== 5'd16 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL overrun_result: got map=%h n=%0d a=%b expected ffff/16/0",
                         spike_map, active_cells, alarm);
    end
    run_frame(16'hFFFF, 1'b1, 8'h77, got);
    n_checks++;
    if (got !== 1'b1 || alarm !== 1'b1 || alarm_intensity !== 8'h77) begin
      n_fail++; $display("FAIL overrun_streak: got uv=%b a=%b ai=%h expected 1/1/77", got, alarm, alarm_intensity);
    end
  endtask

  task automatic test_reset_mid();
    int uv_seen;
    do_reset();
    run_frame(16'h0021, 1'b1, 8'h42, got);
    run_frame(16'h0001, 1'b1, 8'h42, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0001 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL rmid_pre1: got uv=%b map=%h a=%b expected 1/0001/0", got, spike_map, alarm);
    end
    run_frame(16'h0021, 1'b1, 8'h42, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0020 || alarm !== 1'b1 || alarm_intensity !== 8'h42) begin
      n_fail++; $display("FAIL rmid_pre2: got uv=%b map=%h a=%b ai=%h expected 1/0020/1/42",
                         got, spike_map, alarm, alarm_intensity);
    end
    grid_activity = 16'h0001; motion_detected = 1'b1; motion_intensity = 8'h42;
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spike_map, active_cells, alarm, alarm_intensity, update_valid, overrun} !== 32'h0) begin
      n_fail++; $display("FAIL rmid_clear: got map=%h n=%0d a=%b ai=%h uv=%b ov=%b expected all 0",
                         spike_map, active_cells, alarm, alarm_intensity, update_valid, overrun);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    uv_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (update_valid) uv_seen++;
    end
    n_checks++;
    if (uv_seen !== 0) begin
      n_fail++; $display("FAIL rmid_no_uv: got %0d update_valid pulses expected 0", uv_seen);
    end
    run_frame(16'h0001, 1'b1, 8'h42, got);
    n_checks++;
    if (got !== 1'b1 || spike_map !== 16'h0000 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after: got uv=%b map=%h a=%b expected 1/0000/0", got, spike_map, alarm);
    end
  endtask

  initial begin
    test_reset();
    test_isolated();
    test_neighbours();
    test_leak_edges();
    test_alarm();
    test_latency_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
